// File: rtl/key_event_queue.sv
// key_event_queue
//
// Turns debounced key level transitions into press/release events and
// queues them in a first-word-fall-through FIFO for the CPU to pop.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   keys      debounced key levels (1 = held), synchronous to clk
//   rd        pop strobe; one event leaves per cycle while high and ev_valid
//   ev_valid  FIFO holds at least one event
//   ev_data   head event {press, 3'b000, key index}, 8'h00 when empty
//   ev_count  number of events currently stored (0..DEPTH)
//   irq       level interrupt, high while events are pending in the FIFO
module key_event_queue #(
    parameter int NKEYS = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NKEYS-1:0]         keys,
    input  logic                     rd,
    output logic                     ev_valid,
    output logic [7:0]               ev_data,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NKEYS-1:0] prev_q;
    logic [NKEYS-1:0] pending_q;
    logic [NKEYS-1:0] pending_d;
    logic [NKEYS-1:0] change;
    logic [NKEYS-1:0] grant;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             grant_any;
    logic             grant_lvl;
    logic [3:0]       grant_idx;
    logic             push;
    logic             pop;
    logic [7:0]       push_data;

    assign change = keys ^ prev_q;

    // Scanner: walk from the top index down so the last hit wins, leaving
    // the lowest pending key granted. A full FIFO stalls the scan so that
    // pending bits are held rather than events being dropped.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 4'd0;
        grant_lvl = 1'b0;
        grant     = '0;
        if (count_q < CW'(DEPTH)) begin
            for (int i = NKEYS - 1; i >= 0; i--) begin
                if (pending_q[i]) begin
                    grant_any = 1'b1;
                    grant_idx = 4'(i);
                    grant_lvl = prev_q[i];
                    grant     = NKEYS'(1) << i;
                end
            end
        end
    end

    assign push      = grant_any;
    assign push_data = {grant_lvl, 3'b000, grant_idx};
    assign pop       = rd && (count_q != '0);

    // XOR lets a second toggle cancel an ungranted event, and re-arms a key
    // whose level changes in the same cycle its previous event is granted.
    assign pending_d = (pending_q & ~grant) ^ change;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            prev_q    <= keys;
            pending_q <= pending_d;
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign ev_valid = (count_q != '0);
    assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign ev_count = count_q;
    assign irq      = ev_valid;

endmodule
